// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM encoding, fill-port select
// values and the bundle of control outputs driven to the pipeline registers.
package pipe_hazard_ctrl_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        IMISS  = 3'd1,
        DMISS  = 3'd2,
        DRAIN  = 3'd3,
        HALTED = 3'd4
    } ctrlState_e;

    localparam logic FILL_I = 1'b0;
    localparam logic FILL_D = 1'b1;

    typedef struct packed {
        logic fillReq;
        logic fillSel;
        logic pcEn;
        logic ifidEn;
        logic ifidFlush;
        logic idexEn;
        logic idexFlush;
        logic exmemEn;
        logic memwbEn;
        logic halted;
    } ctrlOut_t;

    localparam ctrlOut_t CTRL_RUN = '{
        fillReq: 1'b0, fillSel: FILL_I, pcEn: 1'b1, ifidEn: 1'b1, ifidFlush: 1'b0,
        idexEn: 1'b1, idexFlush: 1'b0, exmemEn: 1'b1, memwbEn: 1'b1, halted: 1'b0
    };

    localparam ctrlOut_t CTRL_FROZEN = '{
        fillReq: 1'b0, fillSel: FILL_I, pcEn: 1'b0, ifidEn: 1'b0, ifidFlush: 1'b0,
        idexEn: 1'b0, idexFlush: 1'b0, exmemEn: 1'b0, memwbEn: 1'b0, halted: 1'b0
    };

    // Hold PC and IF/ID, feed a bubble into EX; EX/MEM/WB keep moving.
    function automatic ctrlOut_t frontStall(input ctrlOut_t base);
        ctrlOut_t o;
        o           = base;
        o.pcEn      = 1'b0;
        o.ifidEn    = 1'b0;
        o.idexFlush = 1'b1;
        return o;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination is read by the
// instruction in ID. Register 0 is hard-wired and never creates a hazard.
module pipe_hazard_ctrl_hazard_detect #(
    parameter int REG_W = 4
) (
    input  logic [REG_W-1:0] srcReg1,
    input  logic [REG_W-1:0] srcReg2,
    input  logic             use1,
    input  logic             use2,
    input  logic             exMemRead,
    input  logic [REG_W-1:0] exDstReg,
    output logic             loadUse
);

    logic hit1;
    logic hit2;

    assign hit1    = use1 && (srcReg1 == exDstReg);
    assign hit2    = use2 && (srcReg2 == exDstReg);
    assign loadUse = exMemRead && (exDstReg != '0) && (hit1 || hit2);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central sequencer for the five-stage pipeline: stalls, flushes, fill-port
// arbitration and halt draining. Define PIPE_HAZARD_PERF_EN to add stall_cnt.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_SrcReg1,
    input  logic [REG_W-1:0] id_SrcReg2,
    input  logic             id_use1,
    input  logic             id_use2,
    input  logic             id_hlt,
    input  logic             br_taken,
    input  logic             ex_MemRead,
    input  logic [REG_W-1:0] ex_DstReg,
    input  logic             wb_hlt,
    input  logic             i_miss,
    input  logic             d_miss,
    input  logic             fill_done,
    output logic             fill_req,
    output logic             fill_sel,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_en,
    output logic             idex_flush,
    output logic             exmem_en,
    output logic             memwb_en,
`ifdef PIPE_HAZARD_PERF_EN
    output logic [CNT_W-1:0] stall_cnt,
`endif
    output logic             halted
);

    if (CNT_W < 1) begin : gCntWidthCheck
        $error("CNT_W must be at least 1");
    end

    ctrlState_e state;
    logic       haltPend;
    logic       loadUse;
    ctrlOut_t   ctrl;

    pipe_hazard_ctrl_hazard_detect #(
        .REG_W(REG_W)
    ) uHazard (
        .srcReg1   (id_SrcReg1),
        .srcReg2   (id_SrcReg2),
        .use1      (id_use1),
        .use2      (id_use2),
        .exMemRead (ex_MemRead),
        .exDstReg  (ex_DstReg),
        .loadUse   (loadUse)
    );

    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= RUN;
            haltPend <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (d_miss) begin
                        state <= DMISS;
                    end else if (i_miss) begin
                        state <= IMISS;
                    end else if (id_hlt && !loadUse) begin
                        state    <= DRAIN;
                        haltPend <= 1'b1;
                    end
                end
                // A concurrent D miss aborts the I fill; the I miss is re-seen from RUN.
                IMISS: begin
                    if (d_miss) begin
                        state <= DMISS;
                    end else if (fill_done) begin
                        state <= RUN;
                    end
                end
                DMISS: begin
                    if (fill_done) begin
                        state <= haltPend ? DRAIN : RUN;
                    end
                end
                DRAIN: begin
                    if (d_miss) begin
                        state <= DMISS;
                    end else if (wb_hlt) begin
                        state <= HALTED;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= RUN;
            endcase
        end
    end

    // NOTE: ctrl gets a full default before the case so no latch is inferred.
    always_comb begin
        ctrl = CTRL_RUN;
        case (state)
            RUN: begin
                if (loadUse) begin
                    ctrl = frontStall(CTRL_RUN);
                end else if (br_taken) begin
                    ctrl.ifidFlush = 1'b1;
                end else if (id_hlt) begin
                    ctrl.pcEn      = 1'b0;
                    ctrl.ifidFlush = 1'b1;
                end
            end
            IMISS: begin
                ctrl         = frontStall(CTRL_RUN);
                ctrl.fillReq = 1'b1;
                ctrl.fillSel = FILL_I;
            end
            DMISS: begin
                ctrl         = CTRL_FROZEN;
                ctrl.fillReq = 1'b1;
                ctrl.fillSel = FILL_D;
            end
            DRAIN: ctrl = frontStall(CTRL_RUN);
            HALTED: begin
                ctrl        = CTRL_FROZEN;
                ctrl.halted = 1'b1;
            end
            default: ctrl = CTRL_RUN;
        endcase
    end

    assign fill_req   = ctrl.fillReq;
    assign fill_sel   = ctrl.fillSel;
    assign pc_en      = ctrl.pcEn;
    assign ifid_en    = ctrl.ifidEn;
    assign ifid_flush = ctrl.ifidFlush;
    assign idex_en    = ctrl.idexEn;
    assign idex_flush = ctrl.idexFlush;
    assign exmem_en   = ctrl.exmemEn;
    assign memwb_en   = ctrl.memwbEn;
    assign halted     = ctrl.halted;

`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stallCnt;

    // Counts cycles the PC is held; saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stallCnt <= '0;
        end else if (!ctrl.pcEn && (state != HALTED) && (stallCnt != '1)) begin
            stallCnt <= stallCnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stallCnt;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; stall_cnt checks are
// compiled in when PIPE_HAZARD_PERF_EN is defined.
module tb_pipe_hazard_ctrl;

    localparam int REG_W = 4;
    localparam int CNT_W = 16;

    // {fill_req, fill_sel, pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, halted}
    localparam logic [9:0] EXP_IDLE   = 10'b0011010110;
    localparam logic [9:0] EXP_STALL  = 10'b0000011110;
    localparam logic [9:0] EXP_BRANCH = 10'b0011110110;
    localparam logic [9:0] EXP_HLT    = 10'b0001110110;
    localparam logic [9:0] EXP_IMISS  = 10'b1000011110;
    localparam logic [9:0] EXP_DMISS  = 10'b1100000000;
    localparam logic [9:0] EXP_HALTED = 10'b0000000001;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [REG_W-1:0] id_SrcReg1, id_SrcReg2, ex_DstReg;
    logic             id_use1, id_use2, id_hlt, br_taken, ex_MemRead;
    logic             wb_hlt, i_miss, d_miss, fill_done;
    logic             fill_req, fill_sel, pc_en, ifid_en, ifid_flush;
    logic             idex_en, idex_flush, exmem_en, memwb_en, halted;
`ifdef PIPE_HAZARD_PERF_EN
    logic [CNT_W-1:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    wire [9:0] obs = {fill_req, fill_sel, pc_en, ifid_en, ifid_flush,
                      idex_en, idex_flush, exmem_en, memwb_en, halted};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_SrcReg1 (id_SrcReg1),
        .id_SrcReg2 (id_SrcReg2),
        .id_use1    (id_use1),
        .id_use2    (id_use2),
        .id_hlt     (id_hlt),
        .br_taken   (br_taken),
        .ex_MemRead (ex_MemRead),
        .ex_DstReg  (ex_DstReg),
        .wb_hlt     (wb_hlt),
        .i_miss     (i_miss),
        .d_miss     (d_miss),
        .fill_done  (fill_done),
        .fill_req   (fill_req),
        .fill_sel   (fill_sel),
        .pc_en      (pc_en),
        .ifid_en    (ifid_en),
        .ifid_flush (ifid_flush),
        .idex_en    (idex_en),
        .idex_flush (idex_flush),
        .exmem_en   (exmem_en),
        .memwb_en   (memwb_en),
`ifdef PIPE_HAZARD_PERF_EN
        .stall_cnt  (stall_cnt),
`endif
        .halted     (halted)
    );

    task automatic clear_inputs;
        id_SrcReg1 = '0; id_SrcReg2 = '0; ex_DstReg = '0;
        id_use1 = 1'b0; id_use2 = 1'b0; id_hlt = 1'b0; br_taken = 1'b0;
        ex_MemRead = 1'b0; wb_hlt = 1'b0; i_miss = 1'b0; d_miss = 1'b0; fill_done = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        #2;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL reset_held got=%b want=%b", obs, EXP_IDLE); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL reset_release got=%b want=%b", obs, EXP_IDLE); end
`ifdef PIPE_HAZARD_PERF_EN
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stall_cnt_reset got=%0d want=0", stall_cnt); end
`endif
    endtask

    task automatic test_load_use;
        @(negedge clk); ex_MemRead = 1'b1; ex_DstReg = 4'd3; id_use2 = 1'b1; id_SrcReg2 = 4'd3; #1;
        total++; if (obs !== EXP_STALL) begin bad++; $display("FAIL load_use_src2 got=%b want=%b", obs, EXP_STALL); end
        @(negedge clk); ex_DstReg = 4'd0; id_SrcReg2 = 4'd0; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL load_use_r0 got=%b want=%b", obs, EXP_IDLE); end
        @(negedge clk); ex_DstReg = 4'd5; id_use2 = 1'b0; id_use1 = 1'b1; id_SrcReg1 = 4'd5; #1;
        total++; if (obs !== EXP_STALL) begin bad++; $display("FAIL load_use_src1 got=%b want=%b", obs, EXP_STALL); end
        @(negedge clk); id_use1 = 1'b0; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL load_use_unused got=%b want=%b", obs, EXP_IDLE); end
        @(negedge clk); id_use1 = 1'b1; ex_MemRead = 1'b0; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL no_load got=%b want=%b", obs, EXP_IDLE); end
        @(negedge clk); clear_inputs();
    endtask

    task automatic test_branch;
        @(negedge clk); ex_MemRead = 1'b1; ex_DstReg = 4'd7; id_use1 = 1'b1; id_SrcReg1 = 4'd7;
        br_taken = 1'b1; id_hlt = 1'b1; #1;
        total++; if (obs !== EXP_STALL) begin bad++; $display("FAIL branch_under_stall got=%b want=%b", obs, EXP_STALL); end
        @(negedge clk); ex_MemRead = 1'b0; id_hlt = 1'b0; #1;
        total++; if (obs !== EXP_BRANCH) begin bad++; $display("FAIL branch_taken got=%b want=%b", obs, EXP_BRANCH); end
        @(negedge clk); clear_inputs(); #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL branch_after got=%b want=%b", obs, EXP_IDLE); end
    endtask

    task automatic test_miss_sequence;
        @(negedge clk); i_miss = 1'b1; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL imiss_entry got=%b want=%b", obs, EXP_IDLE); end
        @(negedge clk); #1;
        total++; if (obs !== EXP_IMISS) begin bad++; $display("FAIL imiss_fill got=%b want=%b", obs, EXP_IMISS); end
        @(negedge clk); #1;
        total++; if (obs !== EXP_IMISS) begin bad++; $display("FAIL imiss_hold got=%b want=%b", obs, EXP_IMISS); end
        @(negedge clk); d_miss = 1'b1; #1;
        total++; if (obs !== EXP_IMISS) begin bad++; $display("FAIL imiss_dmiss_arrive got=%b want=%b", obs, EXP_IMISS); end
        @(negedge clk); #1;
        total++; if (obs !== EXP_DMISS) begin bad++; $display("FAIL dmiss_preempt got=%b want=%b", obs, EXP_DMISS); end
        @(negedge clk); fill_done = 1'b1; #1;
        total++; if (obs !== EXP_DMISS) begin bad++; $display("FAIL dmiss_done_cycle got=%b want=%b", obs, EXP_DMISS); end
        @(negedge clk); fill_done = 1'b0; d_miss = 1'b0; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL dmiss_to_run got=%b want=%b", obs, EXP_IDLE); end
        @(negedge clk); #1;
        total++; if (obs !== EXP_IMISS) begin bad++; $display("FAIL imiss_reissue got=%b want=%b", obs, EXP_IMISS); end
        fill_done = 1'b1; i_miss = 1'b0;
        @(negedge clk); fill_done = 1'b0; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL imiss_done got=%b want=%b", obs, EXP_IDLE); end
        fill_done = 1'b1;
        @(negedge clk); fill_done = 1'b0; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL stray_fill_done got=%b want=%b", obs, EXP_IDLE); end
        i_miss = 1'b1;
        @(negedge clk); i_miss = 1'b0; d_miss = 1'b1; fill_done = 1'b1; #1;
        total++; if (obs !== EXP_IMISS) begin bad++; $display("FAIL imiss_race got=%b want=%b", obs, EXP_IMISS); end
        @(negedge clk); fill_done = 1'b0; #1;
        total++; if (obs !== EXP_DMISS) begin bad++; $display("FAIL dmiss_wins_race got=%b want=%b", obs, EXP_DMISS); end
        @(negedge clk); fill_done = 1'b1; #1;
        total++; if (obs !== EXP_DMISS) begin bad++; $display("FAIL dmiss_race_hold got=%b want=%b", obs, EXP_DMISS); end
        @(negedge clk); clear_inputs(); #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL race_to_run got=%b want=%b", obs, EXP_IDLE); end
    endtask

    task automatic test_halt;
        @(negedge clk); id_hlt = 1'b1; #1;
        total++; if (obs !== EXP_HLT) begin bad++; $display("FAIL hlt_in_id got=%b want=%b", obs, EXP_HLT); end
        @(negedge clk); id_hlt = 1'b0; #1;
        total++; if (obs !== EXP_STALL) begin bad++; $display("FAIL drain got=%b want=%b", obs, EXP_STALL); end
        @(negedge clk); d_miss = 1'b1; #1;
        total++; if (obs !== EXP_STALL) begin bad++; $display("FAIL drain_dmiss_arrive got=%b want=%b", obs, EXP_STALL); end
        @(negedge clk); fill_done = 1'b1; #1;
        total++; if (obs !== EXP_DMISS) begin bad++; $display("FAIL drain_dmiss got=%b want=%b", obs, EXP_DMISS); end
        @(negedge clk); d_miss = 1'b0; fill_done = 1'b0; #1;
        total++; if (obs !== EXP_STALL) begin bad++; $display("FAIL dmiss_back_to_drain got=%b want=%b", obs, EXP_STALL); end
        wb_hlt = 1'b1;
        @(negedge clk); wb_hlt = 1'b0; #1;
        total++; if (obs !== EXP_HALTED) begin bad++; $display("FAIL halted_entry got=%b want=%b", obs, EXP_HALTED); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            i_miss = i[0]; d_miss = i[1]; fill_done = i[0]; id_hlt = i[2]; #1;
            total++; if (obs !== EXP_HALTED) begin bad++; $display("FAIL halted_hold[%0d] got=%b want=%b", i, obs, EXP_HALTED); end
        end
        clear_inputs();
`ifdef PIPE_HAZARD_PERF_EN
        // 2 load-use + 1 branch-stall + 9 miss cycles + 5 halt/drain cycles
        total++; if (stall_cnt !== 16'd17) begin bad++; $display("FAIL stall_cnt_total got=%0d want=17", stall_cnt); end
`endif
    endtask

    task automatic test_reset_mid_fill;
        @(negedge clk); rst = 1'b0; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL reset_from_halted got=%b want=%b", obs, EXP_IDLE); end
        @(negedge clk); rst = 1'b1;
        @(negedge clk); d_miss = 1'b1;
        @(negedge clk); #1;
        total++; if (obs !== EXP_DMISS) begin bad++; $display("FAIL dmiss_before_reset got=%b want=%b", obs, EXP_DMISS); end
        @(negedge clk); #2; rst = 1'b0; #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL reset_mid_dmiss got=%b want=%b", obs, EXP_IDLE); end
`ifdef PIPE_HAZARD_PERF_EN
        total++; if (stall_cnt !== 16'd0) begin bad++; $display("FAIL stall_cnt_async_clear got=%0d want=0", stall_cnt); end
`endif
        @(negedge clk); clear_inputs(); rst = 1'b1;
        @(negedge clk); #1;
        total++; if (obs !== EXP_IDLE) begin bad++; $display("FAIL after_reset_run got=%b want=%b", obs, EXP_IDLE); end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_miss_sequence();
        test_halt();
        test_reset_mid_fill();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the five-stage 16-bit pipeline.
- Generates write enables and flushes for the ifid/idex/exmem/memwb pipeline registers and pc_en for the PC.
- Detects load-use hazards, squashes on taken branches, and arbitrates the single memory fill port between I-cache and D-cache misses.
- Sequences halt: drains the pipe until hlt retires in WB, then freezes.

Parameters:
- REG_W, 4, register-specifier width
- CNT_W, 16, width of stall performance counter (optional feature only)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- id_SrcReg1  in  REG_W  ID-stage source register 1
- id_SrcReg2  in  REG_W  ID-stage source register 2
- id_use1  in  1  ID instruction reads SrcReg1
- id_use2  in  1  ID instruction reads SrcReg2
- id_hlt  in  1  ID instruction is hlt
- br_taken  in  1  branch resolved taken in ID
- ex_MemRead  in  1  EX instruction is a load
- ex_DstReg  in  REG_W  EX destination register
- wb_hlt  in  1  hlt in WB stage (q_hlt of memwb)
- i_miss  in  1  I-cache miss, level
- d_miss  in  1  D-cache miss, level
- fill_done  in  1  one-cycle pulse, granted fill complete
- fill_req  out  1  request to memory fill port
- fill_sel  out  1  0 = I-cache fill, 1 = D-cache fill
- pc_en  out  1  PC write enable
- ifid_en  out  1  ifid register enable
- ifid_flush  out  1  ifid bubble insert
- idex_en  out  1  idex register enable
- idex_flush  out  1  idex bubble insert
- exmem_en  out  1  exmem register enable
- memwb_en  out  1  memwb register enable
- halted  out  1  processor halted, sticky

Behaviour:
- FSM states: RUN, IMISS, DMISS, DRAIN, HALTED. One register halt_pend.
- Reset (rst=0, async): state=RUN, halt_pend=0. All outputs are Moore/combinational from state, so the reset values are: all *_en=1, all flush=0, fill_req=0, fill_sel=0, halted=0.
- load_use = ex_MemRead & ex_DstReg!=0 & ((id_use1 & id_SrcReg1==ex_DstReg) | (id_use2 & id_SrcReg2==ex_DstReg)).
- RUN outputs:
  - All enables 1.
  - If load_use: pc_en=0, ifid_en=0, idex_flush=1; br_taken and id_hlt are ignored this cycle.
  - Else if br_taken: ifid_flush=1.
  - Else if id_hlt: pc_en=0, ifid_flush=1.
- RUN transitions (priority order):
  - d_miss -> DMISS.
  - i_miss -> IMISS.
  - id_hlt & !load_use -> DRAIN, setting halt_pend=1.
- IMISS:
  - Outputs: pc_en=0, ifid_en=0, idex_flush=1; downstream stages run. fill_req=1, fill_sel=0.
  - Transitions: d_miss -> DMISS (I fill abandoned, reissued later); else fill_done -> RUN.
- DMISS:
  - Outputs: all enables 0, no flushes. fill_req=1, fill_sel=1.
  - Transition on fill_done: -> DRAIN if halt_pend, else -> RUN. A still-asserted i_miss is handled from RUN next cycle.
- DRAIN:
  - Outputs: pc_en=0, ifid_en=0, idex_flush=1; exmem/memwb run.
  - Transitions: d_miss -> DMISS; wb_hlt -> HALTED.
- HALTED: all enables 0, halted=1. Left only by reset.
- fill_done outside IMISS/DMISS is ignored. fill_done together with d_miss in IMISS: d_miss wins.
- Reset mid-fill: fill_req drops immediately (async). The memory side must abort the fill.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined: adds output stall_cnt [CNT_W-1:0], reset 0. It increments every cycle pc_en=0 while state!=HALTED, saturates at all-ones, and holds in HALTED.
- Undefined: no counter and no port; all other behaviour is identical.

Decomposition:
- Shared package: state encoding constants (RUN=0, IMISS=1, DMISS=2, DRAIN=3, HALTED=4, 3-bit) and FILL_I/FILL_D constants.
- Natural sub-module: hazard_detect, purely combinational, producing load_use from the ID/EX fields. FSM and output decode stay in the top level.

Test Plan:
- Reset release with idle inputs -> all enables 1, flushes 0, fill_req 0, halted 0.
- ex_MemRead=1, ex_DstReg=3, id_use2=1, id_SrcReg2=3 -> one cycle pc_en=0, ifid_en=0, idex_flush=1. Same with ex_DstReg=0 -> no stall.
- br_taken=1 with load_use active -> stall only, ifid_flush=0. Next cycle load_use=0, br_taken=1 -> ifid_flush=1.
- Sequence:
  - i_miss=1 -> IMISS, fill_req=1, fill_sel=0.
  - 2 cycles later d_miss=1 -> fill_sel=1, all enables 0.
  - fill_done -> RUN.
  - i_miss still 1 -> IMISS next cycle.
- id_hlt=1 -> DRAIN.
  - d_miss during drain -> DMISS; fill_done -> back to DRAIN.
  - wb_hlt=1 -> halted=1, all enables 0, held for 10 cycles.
- Assert rst low mid-DMISS -> fill_req=0 and enables=1 in the same cycle, without waiting for a clock edge. With PIPE_HAZARD_PERF_EN, stall_cnt=0 and it counts exactly the number of stall cycles driven.
